debug_bus_master: RTL and testbench

//  Initiator end of the shared debug bus: turns host commands into one bus transaction each.

---
 rtl/debug_bus_pkg.sv | 8 +
 rtl/debug_bus_master.sv | 130 +++++++++++++
 tb/tb_debug_bus_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_bus_pkg.sv
// debug_bus_pkg: shared widths, status codes and master state encoding for the debug bus.
package debug_bus_pkg;
    localparam int DBG_ADDR_W = 8;
    localparam int DBG_DATA_W = 64;
    localparam logic [DBG_ADDR_W-1:0] DBG_ADDR_NONE = 8'd0;
    typedef enum logic [1:0] {DBG_OK, DBG_TIMEOUT, DBG_BADADDR} dbg_status_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_AVL, RESP, GAP} dbg_master_state_t;
endpackage

// File: rtl/debug_bus_master.sv
// debug_bus_master: turns host commands into single debug bus transactions and returns the response.
// Define DEBUG_BUS_MASTER_TIMEOUT_EN to bound each wait state by TIMEOUT_CYCLES.
module debug_bus_master
    import debug_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DBG_ADDR_W-1:0] cmd_addr,
    input  logic [DBG_DATA_W-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DBG_DATA_W-1:0] rsp_data,
    output logic [1:0]            rsp_status,
    output logic [DBG_ADDR_W-1:0] debug_bus_addr,
    output logic                  debug_bus_start,
    inout  wire  [DBG_DATA_W-1:0] debug_bus_data,
    input  logic                  debug_bus_accepted,
    input  logic                  debug_bus_available
);
    localparam int GW = $clog2(GAP_CYCLES);

    if (GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("debug_bus_master: GAP_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    dbg_master_state_t     state_q, state_d;
    dbg_status_t           status_q, status_d;
    logic [DBG_ADDR_W-1:0] addr_q, addr_d;
    logic [DBG_DATA_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  tmo_hit;

`ifdef DEBUG_BUS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    // Restarts on every state change, so entering either wait state begins a fresh window.
    always_comb begin
        tmo_d = (state_d == state_q && (state_q == WAIT_ACC || state_q == WAIT_AVL)) ? tmo_q + 1'b1 : '0;
    end
    assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        gap_d      = gap_q;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d = cmd_addr;
                data_d = cmd_data;
                if (cmd_addr == DBG_ADDR_NONE) begin
                    state_d    = RESP;
                    status_d   = DBG_BADADDR;
                    rsp_data_d = '0;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_ACC;
            WAIT_ACC: if (debug_bus_accepted == 1'b1 && debug_bus_available == 1'b1) begin
                state_d    = RESP;
                status_d   = DBG_OK;
                rsp_data_d = debug_bus_data;
            end else if (debug_bus_accepted == 1'b1) begin
                state_d = WAIT_AVL;
            end else if (tmo_hit) begin
                state_d    = RESP;
                status_d   = DBG_TIMEOUT;
                rsp_data_d = '0;
            end
            WAIT_AVL: if (debug_bus_available == 1'b1) begin
                state_d    = RESP;
                status_d   = DBG_OK;
                rsp_data_d = debug_bus_data;
            end else if (tmo_hit) begin
                state_d    = RESP;
                status_d   = DBG_TIMEOUT;
                rsp_data_d = '0;
            end
            RESP: if (rsp_ready) begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                 else gap_d = gap_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            status_q   <= DBG_OK;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            gap_q      <= gap_d;
        end
    end

    // Gated by rst so the host never sees ready while reset is held.
    assign cmd_ready       = (state_q == IDLE) && !rst;
    assign rsp_valid       = state_q == RESP;
    assign rsp_data        = rsp_data_q;
    assign rsp_status      = status_q;
    assign debug_bus_start = state_q == ISSUE;
    assign debug_bus_addr  = (state_q inside {ISSUE, WAIT_ACC, WAIT_AVL}) ? addr_q : DBG_ADDR_NONE;
    assign debug_bus_data  = (state_q == ISSUE) ? data_q : 'z;
endmodule

// File: tb/tb_debug_bus_master.sv
// tb_debug_bus_master: random and directed commands against a register-file responder (addr 1)
// and a word-swap responder (addr 2), checked by a queue scoreboard fed from a behavioural model.
module tb_debug_bus_master;
    import debug_bus_pkg::*;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int GAP_CYCLES     = 2;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] req;
        logic [1:0]  st;
        logic [63:0] data;
        int          lat;
        bit          from_issue;
    } exp_t;

    logic        clk = 0, rst = 1;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, debug_bus_start;
    logic [7:0]  cmd_addr, debug_bus_addr;
    logic [63:0] cmd_data, rsp_data;
    logic [1:0]  rsp_status;
    wire  [63:0] debug_bus_data;
    logic        debug_bus_accepted, debug_bus_available;
    logic        resp_acc, resp_avl, resp_drv, stray_acc, stray_avl;
    logic [63:0] resp_word;
    int          cfg_acc_dly, cfg_avl_dly;
    bit          cfg_both;
    logic [31:0] dev_regs [16];
    logic [31:0] mdl_regs [16];
    exp_t        q [$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    int          issue_cyc, acc_cyc, first_cyc, prev_issue, hs_cyc;
    bit          have_issue, have_hs, prev_valid;

    assign debug_bus_accepted  = resp_acc | stray_acc;
    assign debug_bus_available = resp_avl | stray_avl;
    assign debug_bus_data      = resp_drv ? resp_word : 'z;

    debug_bus_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .debug_bus_addr(debug_bus_addr), .debug_bus_start(debug_bus_start), .debug_bus_data(debug_bus_data),
        .debug_bus_accepted(debug_bus_accepted), .debug_bus_available(debug_bus_available)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [63:0] d, input int da, input int dv, input bit both);
        exp_t e;
        e.addr = a; e.req = d; e.from_issue = 1; e.st = 2'(DBG_OK);
        e.lat = both ? 2 + da : 3 + da + dv;
        if (a == 0) begin
            e.st = 2'(DBG_BADADDR); e.data = 0; e.lat = 1; e.from_issue = 0;
        end else if (a == 2) begin
            e.data = {d[31:0], d[63:32]};
        end else if (a == 1) begin
            if (d[0]) begin mdl_regs[d[4:1]] = d[63:32]; e.data = 64'h1; end
            else e.data = {32'h0, mdl_regs[d[4:1]]};
        end else begin
            e.st = 2'(DBG_TIMEOUT); e.data = 0; e.lat = TIMEOUT_CYCLES + 1;
        end
        return e;
    endfunction

    // Behavioural responders: register file at address 1, word swapper at address 2.
    initial begin
        logic [63:0] req, w;
        resp_acc = 0; resp_avl = 0; resp_drv = 0; resp_word = 0;
        for (int i = 0; i < 16; i++) dev_regs[i] = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst && debug_bus_start && (debug_bus_addr == 1 || debug_bus_addr == 2)) begin
                req = debug_bus_data;
                if (debug_bus_addr == 2) w = {req[31:0], req[63:32]};
                else if (req[0]) begin dev_regs[req[4:1]] = req[63:32]; w = 64'h1; end
                else w = {32'h0, dev_regs[req[4:1]]};
                @(posedge clk); #1;
                repeat (cfg_acc_dly) begin @(posedge clk); #1; end
                if (cfg_both) begin
                    resp_acc = 1; resp_avl = 1; resp_drv = 1; resp_word = w;
                    @(posedge clk); #1;
                    resp_acc = 0; resp_avl = 0; resp_drv = 0;
                end else begin
                    resp_acc = 1;
                    @(posedge clk); #1;
                    resp_acc = 0;
                    repeat (cfg_avl_dly) begin @(posedge clk); #1; end
                    resp_avl = 1; resp_drv = 1; resp_word = w;
                    @(posedge clk); #1;
                    resp_avl = 0; resp_drv = 0;
                end
            end
        end
    end

    // Monitor: scoreboard pops on each response handshake; also checks issue, spacing and gap timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0; have_issue = 0; have_hs = 0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (q.size() != 0 && q[0].st == 2'(DBG_BADADDR)) chk("badaddr_no_start", debug_bus_start, 0);
            if (debug_bus_start) begin
                issue_cyc = cyc;
                if (q.size() == 0) chk("start_without_cmd", debug_bus_start, 0);
                else begin
                    chk("issue_addr", debug_bus_addr, q[0].addr);
                    chk("issue_data", debug_bus_data, q[0].req);
                end
                if (have_issue) chk("issue_spacing_ok", 64'((cyc - prev_issue) >= 4 + GAP_CYCLES), 1);
                prev_issue = cyc; have_issue = 1;
            end
            if (have_hs && cyc - hs_cyc >= 1 && cyc - hs_cyc <= GAP_CYCLES) chk("gap_cmd_ready", cmd_ready, 0);
            if (have_hs && cyc - hs_cyc == GAP_CYCLES + 1) chk("post_gap_cmd_ready", cmd_ready, 1);
            if (rsp_valid) begin
                if (!prev_valid) first_cyc = cyc;
                if (q.size() == 0) chk("rsp_without_cmd", rsp_valid, 0);
                else begin
                    chk("rsp_status", rsp_status, q[0].st);
                    chk("rsp_data", rsp_data, q[0].data);
                    chk("rsp_latency", 64'(first_cyc - (q[0].from_issue ? issue_cyc : acc_cyc)), 64'(q[0].lat));
                    chk("resp_bus_addr", debug_bus_addr, 0);
                    chk("resp_start", debug_bus_start, 0);
                    chk("resp_cmd_ready", cmd_ready, 0);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        hs_cyc = cyc; have_hs = 1;
                    end
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic run_cmd(input logic [7:0] a, input logic [63:0] d, input int da, input int dv,
                           input bit both, input int hold, input bit stray);
        int n;
        cfg_acc_dly = da; cfg_avl_dly = dv; cfg_both = both;
        rsp_ready = (hold == 0);
        cmd_addr = a; cmd_data = d; cmd_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", cmd_ready, 1);
            cmd_valid = 0;
            return;
        end
        q.push_back(model(a, d, da, dv, both));
        @(posedge clk); #1;
        cmd_valid = 0; cmd_addr = 8'($urandom); cmd_data = {$urandom, $urandom};
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            chk("rsp_wait_timeout", rsp_valid, 1);
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1;
        end
        @(posedge clk); #1;
        rsp_ready = 0;
        if (stray) begin
            stray_acc = 1; stray_avl = 1;
            @(posedge clk); #1;
            stray_acc = 0; stray_avl = 0;
        end
    endtask

    initial begin
        logic [3:0] idx;
        logic [7:0] a;
        logic [63:0] d;
        int r;
        cmd_valid = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
        stray_acc = 0; stray_avl = 0; cfg_acc_dly = 0; cfg_avl_dly = 0; cfg_both = 0;
        for (int i = 0; i < 16; i++) mdl_regs[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_status", rsp_status, 0);
        chk("reset_bus_addr", debug_bus_addr, 0);
        chk("reset_bus_start", debug_bus_start, 0);
        rst = 0;
        @(posedge clk); #1;
        run_cmd(8'd1, {32'hDEADBEEF, 27'd0, 4'd3, 1'b1}, 0, 0, 0, 0, 0);
        run_cmd(8'd1, 64'h6, 0, 0, 0, 0, 0);
        run_cmd(8'd1, {32'h1234, 27'd0, 4'd5, 1'b1}, 0, 0, 0, 0, 1);
        run_cmd(8'd1, 64'h0A, 0, 0, 0, 0, 0);
        run_cmd(8'd0, 64'hFFFF_0000_1234_5678, 0, 0, 0, 0, 0);
        run_cmd(8'd2, 64'h0123_4567_89AB_CDEF, 1, 2, 0, 10, 0);
        run_cmd(8'd2, 64'hCAFE_F00D_0BAD_BEEF, 2, 0, 1, 0, 1);
        run_cmd(8'd0, 64'h1, 0, 0, 0, 10, 0);
`ifdef DEBUG_BUS_MASTER_TIMEOUT_EN
        run_cmd(8'd7, 64'h55, 0, 0, 0, 0, 0);
        run_cmd(8'd1, 64'h0A, 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? 8'd0 : (r < 7) ? 8'd1 : 8'd2;
            idx = 4'($urandom_range(0, 15));
            d = (a == 8'd1) ? {$urandom, 27'($urandom), idx, 1'($urandom_range(0, 1))} : {$urandom, $urandom};
            run_cmd(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        // Abort a read while the responder is still withholding available.
        cfg_acc_dly = 0; cfg_avl_dly = 8; cfg_both = 0; rsp_ready = 1;
        cmd_addr = 8'd1; cmd_data = 64'h6; cmd_valid = 1;
        r = 0;
        do begin @(negedge clk); r++; end while (!cmd_ready && r < 100);
        q.push_back(model(8'd1, 64'h6, 0, 8, 0));
        @(posedge clk); #1;
        cmd_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("wait_avl_bus_addr", debug_bus_addr, 8'd1);
        rst = 1;
        q.delete();
        #1;
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_data", rsp_data, 0);
        chk("abort_rsp_status", rsp_status, 0);
        chk("abort_bus_addr", debug_bus_addr, 0);
        chk("abort_bus_start", debug_bus_start, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (15) begin
            @(negedge clk);
            chk("post_abort_no_rsp", rsp_valid, 0);
        end
        chk("post_abort_cmd_ready", cmd_ready, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
